hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Producer-side hazard control for the 5-stage pipeline; the counterpart of the EX-stage forwarding selector.
//  Tracks destination-register tags from ID through EX/MEM/WB and exports the ex/mem/wb tags the forwarding
//  selector compares against. Forwarding cannot cover load-use, so this block interlocks those cases
//  (stall IF/ID, bubble into EX). It also squashes IF/ID after a taken branch and counts stall/flush cycles.
// PARAMETERS
//  REG_W        5   register-number width
//  FLUSH_CYCLES 2   cycles flush_if/flush_id stay high per taken branch (>=1)
//  CNT_W        16  width of stall_cnt/flush_cnt (saturating)
// PORTS
//  clk        in   1      pipeline clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  id_valid   in   1      ID stage holds a real instruction
//  id_rs      in   REG_W  ID source register 1
//  id_rt      in   REG_W  ID source register 2
//  id_use_rs  in   1      ID instruction reads id_rs
//  id_use_rt  in   1      ID instruction reads id_rt
//  id_rw      in   REG_W  ID destination register
//  id_regwr   in   1      ID instruction writes id_rw
//  id_load    in   1      ID instruction is a load
//  br_taken   in   1      EX resolved a taken branch/jump this cycle
//  stall_pc   out  1      hold PC
//  stall_id   out  1      hold IF/ID register
//  bubble_ex  out  1      ID/EX loads a NOP this edge
//  flush_if   out  1      squash IF/ID contents
//  flush_id   out  1      squash ID/EX contents
//  ex_rw      out  REG_W  EX dest tag (0 if no write)
//  mem_rw     out  REG_W  MEM dest tag (0 if no write)
//  wb_rw      out  REG_W  WB dest tag (0 if no write)
//  stall_cnt  out  CNT_W  cycles with stall_pc=1
//  flush_cnt  out  CNT_W  taken branches seen
// BEHAVIOUR
//  Reset: all tag regs {rw,regwr,load}=0, state=RUN, flush counter=0, both counters=0 => every output 0.
//  Tag pipe: EX<=MEM<=WB shift every edge, never stalled. EX slot loads ID tags when id_valid & !bubble_ex;
//    otherwise it loads the bubble {0,0,0}. Exported *_rw = rw when regwr=1, else 0.
//  load_use (comb) = ex.load & ex.regwr & ex.rw!=0 &
//    ((id_use_rs & id_rs==ex.rw) | (id_use_rt & id_rt==ex.rw)) & id_valid.
//  Reg 0 never causes a hazard. A non-load producer in EX/MEM/WB never stalls (forwarding covers it).
//  FSM: RUN, FLUSH.
//   RUN: br_taken -> flush_if=flush_id=bubble_ex=1, stall_*=0 (branch wins over load_use). Go to FLUSH with
//        fcnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else stay in RUN.
//        else load_use -> stall_pc=stall_id=bubble_ex=1 for exactly 1 cycle (the bubble clears ex.load next cycle).
//   FLUSH: flush_if=flush_id=bubble_ex=1, stalls=0; fcnt decrements; at fcnt==1 go to RUN.
//        A br_taken while in FLUSH reloads fcnt=FLUSH_CYCLES-1 and counts as a new branch.
//  All control outputs are combinational from state + current inputs (same-cycle effect).
//  Counters: stall_cnt+1 on each cycle with stall_pc; flush_cnt+1 on each br_taken cycle.
//    Both saturate at all-ones (no wrap).
//  rst mid-FLUSH or mid-stall: immediate return to reset values; no residual flush after release.
// TESTING
//  lw r5 in EX, ID add r6,r5,r1 (use_rs) -> stall_pc=stall_id=bubble_ex=1 one cycle; next cycle ex_rw=0,
//    mem_rw=5, no stall; stall_cnt=1.
//  add r5 in EX, ID uses r5 -> no stall; ex_rw=5, then mem_rw=5, then wb_rw=5 on successive cycles.
//  lw r0 in EX, ID uses r0 -> no stall; ex_rw reads 0.
//  br_taken=1 in the same cycle as load_use -> flush_if=flush_id=1 for 2 cycles, stall_pc=0 throughout;
//    flush_cnt=1, stall_cnt=0.
//  br_taken, then rst asserted during the 2nd flush cycle -> all outputs 0 asynchronously;
//    after release flush_if=0.
//  CNT_W=4, hold a load_use 20 times -> stall_cnt stops at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Load-use interlock, taken-branch squash and destination-tag pipe for the 5-stage pipeline.
// Also exports the EX/MEM/WB write tags that the forwarding selector compares against.
//
// state    | meaning
// ST_RUN   | normal issue; interlock on load-use, squash on a taken branch
// ST_FLUSH | squashing IF/ID after a taken branch, fcnt_q cycles left
module hazard_stall_ctrl #(
   parameter int REG_W        = 5,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [REG_W-1:0] id_rw,
   input  logic             id_regwr,
   input  logic             id_load,
   input  logic             br_taken,
   output logic             stall_pc,
   output logic             stall_id,
   output logic             bubble_ex,
   output logic             flush_if,
   output logic             flush_id,
   output logic [REG_W-1:0] ex_rw,
   output logic [REG_W-1:0] mem_rw,
   output logic [REG_W-1:0] wb_rw,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

   state_t           state_q, state_d;
   logic [FC_W-1:0]  fcnt_q, fcnt_d;
   logic [REG_W-1:0] ex_rw_q, ex_rw_d, mem_rw_q, mem_rw_d, wb_rw_q, wb_rw_d;
   logic             ex_regwr_q, ex_regwr_d, mem_regwr_q, mem_regwr_d, wb_regwr_q, wb_regwr_d;
   logic             ex_load_q, ex_load_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   logic load_use, flush, stall;

   always_comb begin
      load_use = ex_load_q && ex_regwr_q && (ex_rw_q != '0) && id_valid &&
                 ((id_use_rs && (id_rs == ex_rw_q)) || (id_use_rt && (id_rt == ex_rw_q)));
      // A taken branch squashes the dependent instruction, so it overrides the interlock.
      flush = br_taken || (state_q == ST_FLUSH);
      stall = load_use && !flush;
   end

   assign stall_pc  = stall;
   assign stall_id  = stall;
   assign bubble_ex = stall || flush;
   assign flush_if  = flush;
   assign flush_id  = flush;

   assign ex_rw     = ex_regwr_q  ? ex_rw_q  : '0;
   assign mem_rw    = mem_regwr_q ? mem_rw_q : '0;
   assign wb_rw     = wb_regwr_q  ? wb_rw_q  : '0;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      if (br_taken) begin
         if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = FC_LOAD;
         end else begin
            state_d = ST_RUN;
         end
      end else if (state_q == ST_FLUSH) begin
         if (fcnt_q == FC_W'(1)) state_d = ST_RUN;
         fcnt_d = fcnt_q - FC_W'(1);
      end
   end

   always_comb begin
      if (id_valid && !bubble_ex) begin
         ex_rw_d    = id_rw;
         ex_regwr_d = id_regwr;
         ex_load_d  = id_load;
      end else begin
         ex_rw_d    = '0;
         ex_regwr_d = 1'b0;
         ex_load_d  = 1'b0;
      end
      mem_rw_d    = ex_rw_q;
      mem_regwr_d = ex_regwr_q;
      wb_rw_d     = mem_rw_q;
      wb_regwr_d  = mem_regwr_q;
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != '1))    stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (br_taken && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         fcnt_q      <= '0;
         ex_rw_q     <= '0;
         ex_regwr_q  <= 1'b0;
         ex_load_q   <= 1'b0;
         mem_rw_q    <= '0;
         mem_regwr_q <= 1'b0;
         wb_rw_q     <= '0;
         wb_regwr_q  <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         fcnt_q      <= fcnt_d;
         ex_rw_q     <= ex_rw_d;
         ex_regwr_q  <= ex_regwr_d;
         ex_load_q   <= ex_load_d;
         mem_rw_q    <= mem_rw_d;
         mem_regwr_q <= mem_regwr_d;
         wb_rw_q     <= wb_rw_d;
         wb_regwr_q  <= wb_regwr_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a default instance plus a 4-bit-counter instance
// sharing the same stimulus so counter saturation can be observed.
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_use_rs, id_use_rt, id_regwr, id_load, br_taken;
   logic [4:0] id_rs, id_rt, id_rw;

   logic        stall_pc, stall_id, bubble_ex, flush_if, flush_id;
   logic [4:0]  ex_rw, mem_rw, wb_rw;
   logic [15:0] stall_cnt, flush_cnt;

   logic        s_stall_pc, s_stall_id, s_bubble_ex, s_flush_if, s_flush_id;
   logic [4:0]  s_ex_rw, s_mem_rw, s_wb_rw;
   logic [3:0]  s_stall_cnt, s_flush_cnt;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl u_dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rw(id_rw), .id_regwr(id_regwr),
      .id_load(id_load), .br_taken(br_taken), .stall_pc(stall_pc), .stall_id(stall_id),
      .bubble_ex(bubble_ex), .flush_if(flush_if), .flush_id(flush_id), .ex_rw(ex_rw),
      .mem_rw(mem_rw), .wb_rw(wb_rw), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   hazard_stall_ctrl #(.CNT_W(4)) u_dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rw(id_rw), .id_regwr(id_regwr),
      .id_load(id_load), .br_taken(br_taken), .stall_pc(s_stall_pc), .stall_id(s_stall_id),
      .bubble_ex(s_bubble_ex), .flush_if(s_flush_if), .flush_id(s_flush_id), .ex_rw(s_ex_rw),
      .mem_rw(s_mem_rw), .wb_rw(s_wb_rw), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one ID-stage instruction: valid, rs, rt, use_rs, use_rt, rw, regwr, load.
   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] rw,
                         input logic wr, input logic ld);
      id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      id_rw = rw; id_regwr = wr; id_load = ld;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      br_taken = 1'b0;
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      br_taken = 1'b0;
      set_id(1, 5, 5, 1, 1, 5, 1, 1);
      #3;
      chk("rst_stall_pc", stall_pc, 0);
      chk("rst_bubble_ex", bubble_ex, 0);
      chk("rst_flush_if", flush_if, 0);
      chk("rst_ex_rw", ex_rw, 0);
      chk("rst_cnts", {stall_cnt, flush_cnt}, 0);
      @(negedge clk);
      rst = 1'b0;

      // lw r5 then add r6,r5,r1
      set_id(1, 0, 0, 0, 0, 5, 1, 1);
      chk("lw_no_stall", stall_pc, 0);
      tick();
      chk("lw_ex_rw", ex_rw, 5);
      set_id(1, 5, 1, 1, 1, 6, 1, 0);
      chk("lu_stall_pc", stall_pc, 1);
      chk("lu_stall_id", stall_id, 1);
      chk("lu_bubble_ex", bubble_ex, 1);
      chk("lu_flush_if", flush_if, 0);
      tick();
      chk("lu_ex_bubble", ex_rw, 0);
      chk("lu_mem_rw", mem_rw, 5);
      chk("lu_released", stall_pc, 0);
      chk("lu_stall_cnt", stall_cnt, 1);

      // add r5 followed by a consumer: forwarded, never stalls
      set_id(1, 0, 0, 0, 0, 5, 1, 0);
      tick();
      chk("fw_ex_rw", ex_rw, 5);
      set_id(1, 5, 0, 1, 0, 7, 1, 0);
      chk("fw_no_stall", stall_pc, 0);
      tick();
      chk("fw_mem_rw", mem_rw, 5);
      chk("fw_ex_rw2", ex_rw, 7);
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("fw_wb_rw", wb_rw, 5);
      chk("fw_ex_invalid", ex_rw, 0);
      chk("fw_mem_rw2", mem_rw, 7);

      // lw r0: register 0 never hazards
      set_id(1, 0, 0, 0, 0, 0, 1, 1);
      tick();
      chk("r0_ex_rw", ex_rw, 0);
      set_id(1, 0, 0, 1, 0, 8, 1, 0);
      chk("r0_no_stall", stall_pc, 0);
      chk("r0_stall_cnt", stall_cnt, 1);

      // taken branch coincident with a load-use
      do_reset();
      set_id(1, 0, 0, 0, 0, 5, 1, 1);
      tick();
      set_id(1, 0, 5, 0, 1, 6, 1, 0);
      br_taken = 1'b1;
      #1;
      chk("br_flush_if", flush_if, 1);
      chk("br_flush_id", flush_id, 1);
      chk("br_stall_pc", stall_pc, 0);
      chk("br_bubble_ex", bubble_ex, 1);
      tick();
      br_taken = 1'b0;
      #1;
      chk("br_flush_if_c2", flush_if, 1);
      chk("br_stall_pc_c2", stall_pc, 0);
      chk("br_flush_cnt", flush_cnt, 1);
      tick();
      chk("br_flush_done", flush_if, 0);
      chk("br_stall_pc_c3", stall_pc, 0);
      chk("br_stall_cnt", stall_cnt, 0);

      // branch, then async reset in the second flush cycle
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      br_taken = 1'b1;
      #1;
      tick();
      br_taken = 1'b0;
      #1;
      chk("rf_flush_before", flush_if, 1);
      rst = 1'b1;
      #1;
      chk("rf_flush_if", flush_if, 0);
      chk("rf_flush_id", flush_id, 0);
      chk("rf_bubble_ex", bubble_ex, 0);
      chk("rf_flush_cnt", flush_cnt, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("rf_after_release", flush_if, 0);
      tick();
      chk("rf_after_edge", flush_if, 0);

      // 20 load-use events: 4-bit counter saturates at 15
      do_reset();
      for (int i = 0; i < 20; i++) begin
         set_id(1, 0, 0, 0, 0, 5, 1, 1);
         tick();
         set_id(1, 5, 0, 1, 0, 6, 1, 0);
         chk("sat_stall", s_stall_pc, 1);
         tick();
      end
      chk("sat_cnt4", s_stall_cnt, 15);
      chk("sat_cnt16", stall_cnt, 20);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
